// File: rtl/booth_mult_if.sv
// rtl/booth_mult_if.sv - start/operand/result signal group for the Booth multiplier
interface booth_mult_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_mult;
    logic [WIDTH-1:0] data_operand_a;
    logic [WIDTH-1:0] data_operand_b;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_result_rdy;
    logic             busy;

    modport master (
        output ctrl_mult, data_operand_a, data_operand_b,
        input  data_result, data_exception, data_result_rdy, busy
    );

    modport slave (
        input  ctrl_mult, data_operand_a, data_operand_b,
        output data_result, data_exception, data_result_rdy, busy
    );
endinterface

// File: rtl/booth_mult_ctrl.sv
// rtl/booth_mult_ctrl.sv - sequential radix-2 Booth multiplier, one step per clock
module booth_mult_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         reset,
    booth_mult_if.slave  bus
);
    localparam int PW = 2 * WIDTH + 2;
    localparam logic [CNT_W-1:0] STEPS = CNT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PW-1:0]    p_q, p_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic [WIDTH:0]   p_hi;
    logic [WIDTH:0]   p_hi_sum;
    logic [PW-1:0]    p_step;
    logic             overflow;

    // P_hi and M carry one guard bit so subtracting the most negative M cannot wrap
    always_comb begin
        p_hi = p_q[PW-1:WIDTH+1];
        case (p_q[1:0])
            2'b01:   p_hi_sum = p_hi + m_q;
            2'b10:   p_hi_sum = p_hi - m_q;
            default: p_hi_sum = p_hi;
        endcase
        p_step   = {p_hi_sum[WIDTH], p_hi_sum, p_q[WIDTH:1]};
        overflow = (p_hi != {(WIDTH+1){p_q[WIDTH]}});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            p_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            p_q      <= p_d;
            m_q      <= m_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        p_d      = p_q;
        m_d      = m_q;
        result_d = result_q;
        exc_d    = exc_q;
        // A start pulse in any state (re)loads the operands; in RUN it aborts the op in flight
        if (bus.ctrl_mult) begin
            state_d = RUN;
            count_d = '0;
            m_d     = {bus.data_operand_a[WIDTH-1], bus.data_operand_a};
            p_d     = {{(WIDTH+1){1'b0}}, bus.data_operand_b, 1'b0};
        end else begin
            case (state_q)
                RUN: begin
                    if (count_q == STEPS) begin
                        state_d  = DONE;
                        result_d = p_q[WIDTH:1];
                        exc_d    = overflow;
                    end else begin
                        p_d     = p_step;
                        count_d = count_q + 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.data_result     = result_q;
    assign bus.data_exception  = exc_q;
    assign bus.data_result_rdy = (state_q == DONE);
    assign bus.busy            = (state_q == RUN);
endmodule
